sa3d_out_collector: RTL and testbench

//  AXI-stream sink for the SA3D_Top result port (m_axis_mm2s). Accepts 64-bit result beats under a

---
 rtl/sa3d_out_collector_if.sv | 18 +
 rtl/sa3d_out_collector.sv | 141 ++++++++++++++
 tb/tb_sa3d_out_collector.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sa3d_out_collector_if.sv
// sa3d_out_collector_if
//   AXI-stream result channel from the SA3D accelerator into the collector.
//   tdata  : result beat
//   tvalid : beat valid (source)
//   tlast  : last beat of a run (source)
//   tready : sink ready (collector)
//   master modport is the stream source, slave modport is the collector.
interface sa3d_out_collector_if #(
    parameter int DATA_W = 64
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/sa3d_out_collector.sv
// sa3d_out_collector
//   Stream sink for accelerator results. Accepts beats under a programmable
//   ready pattern, writes each beat to a result RAM at an incrementing address,
//   checks that tlast lands on the expected beat, and can re-arm itself for
//   back-to-back runs.
// Ports
//   clk, reset_n        clock, async active-low reset
//   start               1-cycle pulse: clear counters/errors and arm capture
//   expected_beats      beats per run incl. the tlast beat; 0 = end on tlast only
//   restart_en          re-arm capture automatically after each run
//   ready_on            tready-high cycles per pattern period
//   ready_period        pattern period in cycles; 0 = always ready
//   s_axis              result stream (slave modport)
//   mem_we/addr/wdata   result RAM write port, one cycle after the accept
//   beat_count          beats accepted in the current/last run
//   busy                high while capturing
//   done                1-cycle pulse at end of run
//   restart             1-cycle pulse coincident with done when re-arming
//   err_early_last      sticky: tlast before expected_beats
//   err_missing_last    sticky: expected_beats reached without tlast
module sa3d_out_collector #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 18,
    parameter int CNT_W  = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [31:0]        expected_beats,
    input  logic               restart_en,
    input  logic [CNT_W-1:0]   ready_on,
    input  logic [CNT_W-1:0]   ready_period,
    sa3d_out_collector_if.slave s_axis,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [31:0]        beat_count,
    output logic               busy,
    output logic               done,
    output logic               restart,
    output logic               err_early_last,
    output logic               err_missing_last
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  pat_cnt;
    logic [ADDR_W-1:0] wr_idx;
    logic              accept;
    logic              bounded;
    logic [31:0]       beat_next;
    logic              count_hit;
    logic              early;

    // Pattern counter runs regardless of FSM state so the ready pattern is a
    // pure function of time since reset and the programmed period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pat_cnt <= '0;
        else if (ready_period == '0 || pat_cnt >= ready_period - 1'b1)
            pat_cnt <= '0;
        else
            pat_cnt <= pat_cnt + 1'b1;
    end

    assign s_axis.tready = (state == CAPTURE) &&
                           (ready_period == '0 || pat_cnt < ready_on);

    assign accept    = s_axis.tvalid && s_axis.tready;
    assign bounded   = (expected_beats != 32'd0);
    assign beat_next = beat_count + 32'd1;
    assign count_hit = bounded && (beat_next == expected_beats);
    assign early     = s_axis.tlast && bounded && (beat_next < expected_beats);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            wr_idx           <= '0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            beat_count       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            restart          <= 1'b0;
            err_early_last   <= 1'b0;
            err_missing_last <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            done    <= 1'b0;
            restart <= 1'b0;
            if (start) begin
                // Abort anything in flight; a beat accepted this cycle is dropped.
                state            <= CAPTURE;
                busy             <= 1'b1;
                beat_count       <= '0;
                wr_idx           <= '0;
                mem_addr         <= '0;
                err_early_last   <= 1'b0;
                err_missing_last <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    CAPTURE: begin
                        if (accept) begin
                            mem_we     <= 1'b1;
                            mem_addr   <= wr_idx;
                            mem_wdata  <= s_axis.tdata;
                            wr_idx     <= wr_idx + 1'b1;
                            beat_count <= beat_next;
                            if (early)
                                err_early_last <= 1'b1;
                            if (count_hit && !s_axis.tlast)
                                err_missing_last <= 1'b1;
                            if (s_axis.tlast || count_hit) begin
                                state   <= DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                restart <= restart_en;
                            end
                        end
                    end
                    DONE: begin
                        // restart was latched on entry, so the re-arm decision
                        // always matches the pulse that was shown.
                        if (restart) begin
                            state      <= CAPTURE;
                            busy       <= 1'b1;
                            beat_count <= '0;
                            wr_idx     <= '0;
                            mem_addr   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sa3d_out_collector.sv
module tb_sa3d_out_collector;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 18;
    localparam int CNT_W  = 10;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       expected_beats = '0;
    logic              restart_en = 1'b0;
    logic [CNT_W-1:0]  ready_on = '0;
    logic [CNT_W-1:0]  ready_period = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [31:0]       beat_count;
    logic              busy, done, restart, err_early_last, err_missing_last;

    sa3d_out_collector_if #(.DATA_W(DATA_W)) s_axis ();

    sa3d_out_collector #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .expected_beats(expected_beats), .restart_en(restart_en),
        .ready_on(ready_on), .ready_period(ready_period), .s_axis(s_axis),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .beat_count(beat_count), .busy(busy), .done(done), .restart(restart),
        .err_early_last(err_early_last), .err_missing_last(err_missing_last)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Write/pulse monitor, sampled on the falling edge.
    logic [63:0]  mem_m [0:255];
    int           wr_cnt = 0, done_cnt = 0, rst_cnt = 0, pat_bad = 0, pat_lo = 0;
    logic [17:0]  last_addr = '0;
    bit           chk_pat = 0;
    logic [CNT_W-1:0] mcnt;

    // Reference ready pattern: counter wraps at ready_period, always-ready at 0.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) mcnt <= '0;
        else if (ready_period == '0 || mcnt >= ready_period - 1'b1) mcnt <= '0;
        else mcnt <= mcnt + 1'b1;
    end

    always @(negedge clk) begin
        if (mem_we) begin
            mem_m[mem_addr[7:0]] <= mem_wdata;
            last_addr <= mem_addr;
            wr_cnt <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (restart) rst_cnt <= rst_cnt + 1;
        if (chk_pat) begin
            if (s_axis.tready !== (busy && (ready_period == '0 || mcnt < ready_on)))
                pat_bad <= pat_bad + 1;
            if (busy && !s_axis.tready) pat_lo <= pat_lo + 1;
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Holds a beat until accepted; returns 1 ns after the accept edge.
    task automatic send(input logic [63:0] d, input bit l);
        bit acc;
        int t = 0;
        s_axis.tdata = d; s_axis.tvalid = 1'b1; s_axis.tlast = l;
        do begin
            acc = s_axis.tready;
            @(posedge clk); #1;
            t++;
        end while (!acc && t < 5000);
        if (!acc) chk("send_timeout", 0, 1);
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    int w0, d0, r0;

    initial begin
        s_axis.tdata = '0; s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_tready", s_axis.tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_count", beat_count, 0);
        chk("rst_err_early", err_early_last, 0);
        chk("rst_err_miss", err_missing_last, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_tready", s_axis.tready, 0);

        // 1: four-beat run, always ready
        expected_beats = 4; w0 = wr_cnt; d0 = done_cnt;
        pulse_start();
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 4; i++) send(64'hA0 + 64'(i), i == 3);
        settle();
        for (int i = 0; i < 4; i++) chk($sformatf("t1_mem%0d", i), mem_m[i], 64'hA0 + 64'(i));
        chk("t1_writes", wr_cnt - w0, 4);
        chk("t1_done_cycles", done_cnt - d0, 1);
        chk("t1_count", beat_count, 4);
        chk("t1_busy_end", busy, 0);
        chk("t1_errs", {err_early_last, err_missing_last}, 0);

        // 2: 32-of-512 ready pattern, 100 beats
        expected_beats = 100; ready_on = 10'd32; ready_period = 10'd512; w0 = wr_cnt;
        pulse_start();
        chk_pat = 1;
        for (int i = 0; i < 100; i++) send(64'h2000_0000_0000_0000 + 64'(i), i == 99);
        settle();
        chk_pat = 0;
        for (int i = 0; i < 100; i++)
            chk($sformatf("t2_mem%0d", i), mem_m[i], 64'h2000_0000_0000_0000 + 64'(i));
        chk("t2_writes", wr_cnt - w0, 100);
        chk("t2_pattern", pat_bad, 0);
        chk("t2_gap_seen", pat_lo != 0, 1);
        chk("t2_count", beat_count, 100);
        ready_on = '0; ready_period = '0;

        // 3: early tlast on beat 5 of 8
        expected_beats = 8; d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 5; i++) send(64'h30 + 64'(i), i == 4);
        settle();
        chk("t3_err_early", err_early_last, 1);
        chk("t3_err_miss", err_missing_last, 0);
        chk("t3_done", done_cnt - d0, 1);
        chk("t3_count", beat_count, 5);
        chk("t3_idle", {busy, s_axis.tready}, 0);

        // 4: count reached without tlast
        d0 = done_cnt;
        pulse_start();
        chk("t4_early_cleared", err_early_last, 0);
        for (int i = 0; i < 8; i++) send(64'h40 + 64'(i), 1'b0);
        settle();
        chk("t4_err_miss", err_missing_last, 1);
        chk("t4_done", done_cnt - d0, 1);
        chk("t4_count", beat_count, 8);
        pulse_start();
        chk("t4_miss_cleared", err_missing_last, 0);
        chk("t4_count_cleared", beat_count, 0);

        // 5: auto re-arm, two 3-beat runs
        expected_beats = 3; restart_en = 1'b1; w0 = wr_cnt; d0 = done_cnt; r0 = rst_cnt;
        pulse_start();
        for (int i = 0; i < 3; i++) send(64'hB0 + 64'(i), i == 2);
        for (int i = 0; i < 3; i++) send(64'hC0 + 64'(i), i == 2);
        settle();
        for (int i = 0; i < 3; i++) chk($sformatf("t5_mem%0d", i), mem_m[i], 64'hC0 + 64'(i));
        chk("t5_writes", wr_cnt - w0, 6);
        chk("t5_last_addr", last_addr, 2);
        chk("t5_done", done_cnt - d0, 2);
        chk("t5_restart", rst_cnt - r0, 2);
        chk("t5_rearmed", busy, 1);
        chk("t5_count_cleared", beat_count, 0);
        restart_en = 1'b0;

        // 6: reset mid-run, then a clean run
        expected_beats = 4; d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 2; i++) send(64'hE0 + 64'(i), 1'b0);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_outs", {busy, done, restart, mem_we, s_axis.tready}, 0);
        chk("t6_rst_count", beat_count, 0);
        chk("t6_rst_addr", mem_addr, 0);
        reset_n = 1'b1;
        settle();
        chk("t6_no_done", done_cnt - d0, 0);
        w0 = wr_cnt;
        pulse_start();
        for (int i = 0; i < 4; i++) send(64'hF0 + 64'(i), i == 3);
        settle();
        for (int i = 0; i < 4; i++) chk($sformatf("t6_mem%0d", i), mem_m[i], 64'hF0 + 64'(i));
        chk("t6_writes", wr_cnt - w0, 4);
        chk("t6_count", beat_count, 4);
        chk("t6_done", done_cnt - d0, 1);
        chk("t6_errs", {err_early_last, err_missing_last}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
